window_feeder: RTL

WINDOW_FEEDER -- requirements
Module: window_feeder

---
 rtl/window_feeder_pkg.sv | 19 +
 rtl/window_feeder_line_buffer.sv | 26 ++
 rtl/window_feeder.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/window_feeder_pkg.sv
// Shared definitions for 3x3 window producers and consumers (window feeder, pooling kernel).
// Holds the default pixel width, window geometry and the (r*3+c) element packing rule.
package window_feeder_pkg;

  localparam int unsigned PIX_W     = 8;
  localparam int unsigned WIN       = 3;
  localparam int unsigned WIN_ELEMS = WIN * WIN;

  typedef enum logic {
    FILL   = 1'b0,
    STREAM = 1'b1
  } feed_state_t;

  // Element (r,c) of a packed window lives at slot r*WIN+c; r=0 is the oldest row, c=0 the oldest column.
  function automatic int unsigned win_pos(input int unsigned r, input int unsigned c);
    return r * WIN + c;
  endfunction

endpackage

// File: rtl/window_feeder_line_buffer.sv
// One image line of pixel storage: read-before-write at a shared column address.
// The old value at addr is visible combinationally while the new pixel is written on the edge.
module line_buffer #(
  parameter int unsigned DWIDTH = 8,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned AW     = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DWIDTH-1:0] wr_data,
  output logic [DWIDTH-1:0] rd_data
);

  // Contents are never reset; stale entries are only read in rows that never emit a window.
  logic [DWIDTH-1:0] mem [DEPTH];

  assign rd_data = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wr_data;
    end
  end

endmodule

// File: rtl/window_feeder.sv
// Raster pixel stream to 3x3 sliding-window stream with valid/ready on both sides.
// Two line buffers supply lines y-1 and y-2; a 3x3 register array shifts left per accepted pixel.
module window_feeder
  import window_feeder_pkg::*;
#(
  parameter int unsigned DWIDTH = PIX_W,
  parameter int unsigned IMG_W  = 8,
  parameter int unsigned IMG_H  = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        pix_valid,
  input  logic [DWIDTH-1:0]           pix_data,
  output logic                        pix_ready,
  output logic                        win_valid,
  output logic [WIN_ELEMS*DWIDTH-1:0] win_data,
  output logic                        win_last,
  input  logic                        win_ready
);

  localparam int unsigned CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(WIN - 1);
  localparam logic [RW-1:0] ROW_PRE   = RW'(WIN - 2);

  feed_state_t       state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic              xfer;
  logic              qualify;
  logic              frame_end;
  logic              win_valid_q;
  logic              win_last_q;
  logic [DWIDTH-1:0] up1;
  logic [DWIDTH-1:0] up2;
  logic [DWIDTH-1:0] win_q [WIN][WIN];

  assign pix_ready = !win_valid_q || win_ready;
  assign xfer      = pix_valid && pix_ready;
  assign win_valid = win_valid_q;
  assign win_last  = win_last_q;

  // lb_y1 holds line y-1 and forwards its displaced entry into lb_y2 (line y-2).
  line_buffer #(
    .DWIDTH (DWIDTH),
    .DEPTH  (IMG_W),
    .AW     (CW)
  ) lb_y1 (
    .clk     (clk),
    .we      (xfer),
    .addr    (col_q),
    .wr_data (pix_data),
    .rd_data (up1)
  );

  line_buffer #(
    .DWIDTH (DWIDTH),
    .DEPTH  (IMG_W),
    .AW     (CW)
  ) lb_y2 (
    .clk     (clk),
    .we      (xfer),
    .addr    (col_q),
    .wr_data (up1),
    .rd_data (up2)
  );

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    row_d     = row_q;
    qualify   = 1'b0;
    frame_end = 1'b0;
    if (xfer) begin
      frame_end = (col_q == COL_LAST) && (row_q == ROW_LAST);
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      unique case (state_q)
        FILL: begin
          if ((col_q == COL_LAST) && (row_q == ROW_PRE)) begin
            state_d = STREAM;
          end
        end
        STREAM: begin
          qualify = (col_q >= COL_FIRST);
          if (frame_end) begin
            state_d = FILL;
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
    end
  end

  // The shift array doubles as the output register: it only moves on a pixel transfer,
  // which cannot happen while an unconsumed window is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < WIN; r++) begin
        for (int unsigned c = 0; c < WIN; c++) begin
          win_q[r][c] <= '0;
        end
      end
    end else if (xfer) begin
      for (int unsigned r = 0; r < WIN; r++) begin
        for (int unsigned c = 0; c < WIN - 1; c++) begin
          win_q[r][c] <= win_q[r][c+1];
        end
      end
      win_q[0][WIN-1] <= up2;
      win_q[1][WIN-1] <= up1;
      win_q[2][WIN-1] <= pix_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end else if (qualify) begin
      win_valid_q <= 1'b1;
      win_last_q  <= frame_end;
    end else if (win_ready) begin
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned r = 0; r < WIN; r++) begin
      for (int unsigned c = 0; c < WIN; c++) begin
        win_data[win_pos(r, c)*DWIDTH +: DWIDTH] = win_q[r][c];
      end
    end
  end

endmodule
